// File: rtl/eth_tx_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : eth_tx_arb_if
// Purpose  : Requester / transmit-controller bundle around the TX arbiter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface eth_tx_arb_if;
  logic        req_0;
  logic        req_1;
  logic        tx_busy;
  logic        gnt_0;
  logic        gnt_1;
  logic        sel;
  logic        eth_pkt_rdy;
  logic        start_err;
  logic [15:0] frm_cnt_0;
  logic [15:0] frm_cnt_1;
  logic [1:0]  arb_state;

  modport master (
    input  req_0, req_1, tx_busy,
    output gnt_0, gnt_1, sel, eth_pkt_rdy, start_err,
    output frm_cnt_0, frm_cnt_1, arb_state
  );

  modport slave (
    output req_0, req_1, tx_busy,
    input  gnt_0, gnt_1, sel, eth_pkt_rdy, start_err,
    input  frm_cnt_0, frm_cnt_1, arb_state
  );
endinterface
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : eth_tx_arb
// Purpose  : Two-requester round-robin arbiter for one Ethernet TX controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module eth_tx_arb #(
  parameter int pIFG_CYCLES = 48,
  parameter int pSTART_TO   = 16
) (
  input  logic         clk,
  input  logic         rst,
  eth_tx_arb_if.master bus
);

  localparam int CNT_MAX = (pIFG_CYCLES > pSTART_TO) ? pIFG_CYCLES : pSTART_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] IFG_LOAD   = CNT_W'(pIFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(pSTART_TO - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_IFG    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_sel_q, last_sel_d;
  logic             sel_q, sel_d;
  logic             gnt_0_q, gnt_0_d;
  logic             gnt_1_q, gnt_1_d;
  logic             pkt_rdy_q, pkt_rdy_d;
  logic             start_err_q, start_err_d;
  logic [15:0]      frm_cnt_0_q, frm_cnt_0_d;
  logic [15:0]      frm_cnt_1_q, frm_cnt_1_d;
  logic             win;

  // On a tie the requester that did not own the last grant wins.
  assign win = (bus.req_0 && bus.req_1) ? ~last_sel_q : bus.req_1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_sel_d  = last_sel_q;
    sel_d       = sel_q;
    gnt_0_d     = gnt_0_q;
    gnt_1_d     = gnt_1_q;
    pkt_rdy_d   = 1'b0;
    start_err_d = 1'b0;
    frm_cnt_0_d = frm_cnt_0_q;
    frm_cnt_1_d = frm_cnt_1_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && (bus.req_0 || bus.req_1)) begin
          state_d    = ST_GRANT;
          cnt_d      = '0;
          last_sel_d = win;
          sel_d      = win;
          gnt_0_d    = ~win;
          gnt_1_d    = win;
          pkt_rdy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.tx_busy) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == START_LAST) begin
          state_d     = ST_IFG;
          start_err_d = 1'b1;
          gnt_0_d     = 1'b0;
          gnt_1_d     = 1'b0;
          cnt_d       = IFG_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!bus.tx_busy) begin
          state_d = ST_IFG;
          gnt_0_d = 1'b0;
          gnt_1_d = 1'b0;
          cnt_d   = IFG_LOAD;
          if (sel_q) begin
            frm_cnt_1_d = frm_cnt_1_q + 16'd1;
          end else begin
            frm_cnt_0_d = frm_cnt_0_q + 16'd1;
          end
        end
      end
      ST_IFG: begin
        // Requests are deliberately not sampled until the gap has elapsed.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_sel_q  <= 1'b1;
      sel_q       <= 1'b0;
      gnt_0_q     <= 1'b0;
      gnt_1_q     <= 1'b0;
      pkt_rdy_q   <= 1'b0;
      start_err_q <= 1'b0;
      frm_cnt_0_q <= 16'd0;
      frm_cnt_1_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_sel_q  <= last_sel_d;
      sel_q       <= sel_d;
      gnt_0_q     <= gnt_0_d;
      gnt_1_q     <= gnt_1_d;
      pkt_rdy_q   <= pkt_rdy_d;
      start_err_q <= start_err_d;
      frm_cnt_0_q <= frm_cnt_0_d;
      frm_cnt_1_q <= frm_cnt_1_d;
    end
  end

  assign bus.gnt_0       = gnt_0_q;
  assign bus.gnt_1       = gnt_1_q;
  assign bus.sel         = sel_q;
  assign bus.eth_pkt_rdy = pkt_rdy_q;
  assign bus.start_err   = start_err_q;
  assign bus.frm_cnt_0   = frm_cnt_0_q;
  assign bus.frm_cnt_1   = frm_cnt_1_q;
  assign bus.arb_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_eth_tx_arb
// Purpose  : Randomised self-checking bench for the Ethernet TX arbiter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_eth_tx_arb;

  localparam int IFG = 48;
  localparam int STO = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_IFG    = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_tx_arb_if bus ();

  eth_tx_arb #(
    .pIFG_CYCLES (IFG),
    .pSTART_TO   (STO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: who owned the last grant, what Sel shows, frames done.
  bit          m_last;
  bit          m_sel;
  logic [15:0] m_cnt [2];
  int          last_fall;

  logic [6:0] obs;
  assign obs = {bus.arb_state, bus.gnt_0, bus.gnt_1, bus.sel, bus.eth_pkt_rdy, bus.start_err};

  function automatic logic [6:0] pack(input logic [1:0] st, input logic g0, input logic g1,
                                      input logic s, input logic rdy, input logic err);
    return {st, g0, g1, s, rdy, err};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (bus.gnt_0 && bus.gnt_1) begin
        n_fail++;
        $display("FAIL gnt_exclusive: gnt_0=%b gnt_1=%b at cycle %0d", bus.gnt_0, bus.gnt_1, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_last    = 1'b1;
    m_sel     = 1'b0;
    m_cnt[0]  = 16'd0;
    m_cnt[1]  = 16'd0;
    last_fall = -1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus.req_0   = 1'b0;
    bus.req_1   = 1'b0;
    bus.tx_busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete arbitration from IDLE: grant, then either a frame of `len`
  // busy cycles starting `dly` cycles after the start pulse, or a timeout.
  task automatic do_frame(input bit r0, input bit r1, input bit to, input int dly, input int len);
    bit         w;
    logic [6:0] e;
    int         gap;
    bus.req_0   = r0;
    bus.req_1   = r1;
    bus.tx_busy = 1'b0;
    w = (r0 && r1) ? ~m_last : r1;
    m_last = w;
    m_sel  = w;
    @(negedge clk);
    e = pack(S_GRANT, ~w, w, w, 1'b1, 1'b0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL grant_entry: got %b want %b (r0=%b r1=%b)", obs, e, r0, r1);
    end
    if (last_fall >= 0) begin
      gap = cyc - last_fall;
      n_chk++;
      if (gap < IFG + 1) begin
        n_fail++;
        $display("FAIL ifg_gap: got %0d cycles want >= %0d", gap, IFG + 1);
      end
    end
    if ($urandom_range(1, 0) == 1) begin
      bus.req_0 = 1'b0;
      bus.req_1 = 1'b0;
    end
    e = pack(S_GRANT, ~w, w, w, 1'b0, 1'b0);
    if (to) begin
      repeat (STO - 1) begin
        @(negedge clk);
        n_chk++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL grant_wait: got %b want %b", obs, e);
        end
      end
      @(negedge clk);
      e = pack(S_IFG, 1'b0, 1'b0, w, 1'b0, 1'b1);
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL start_err: got %b want %b", obs, e);
      end
      last_fall = -1;
    end else begin
      repeat (dly) begin
        @(negedge clk);
        n_chk++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL grant_wait: got %b want %b", obs, e);
        end
      end
      bus.tx_busy = 1'b1;
      e = pack(S_ACTIVE, ~w, w, w, 1'b0, 1'b0);
      repeat (len) begin
        @(negedge clk);
        n_chk++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL active_hold: got %b want %b", obs, e);
        end
      end
      bus.tx_busy = 1'b0;
      last_fall   = cyc;
      @(negedge clk);
      m_cnt[w] = m_cnt[w] + 16'd1;
      e = pack(S_IFG, 1'b0, 1'b0, w, 1'b0, 1'b0);
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ifg_entry: got %b want %b", obs, e);
      end
    end
    n_chk++;
    if ({bus.frm_cnt_0, bus.frm_cnt_1} !== {m_cnt[0], m_cnt[1]}) begin
      n_fail++;
      $display("FAIL frm_cnt: got %h/%h want %h/%h", bus.frm_cnt_0, bus.frm_cnt_1, m_cnt[0], m_cnt[1]);
    end
    bus.req_0 = 1'($urandom_range(1, 0));
    bus.req_1 = 1'($urandom_range(1, 0));
    e = pack(S_IFG, 1'b0, 1'b0, w, 1'b0, 1'b0);
    repeat (IFG - 1) begin
      @(negedge clk);
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ifg_hold: got %b want %b", obs, e);
      end
    end
    @(negedge clk);
    e = pack(S_IDLE, 1'b0, 1'b0, w, 1'b0, 1'b0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL ifg_exit: got %b want %b", obs, e);
    end
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.req_0   = 1'b1;
    bus.req_1   = 1'b1;
    bus.tx_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs !== pack(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", obs, pack(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    n_chk++;
    if ({bus.frm_cnt_0, bus.frm_cnt_1} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %h/%h want 0/0", bus.frm_cnt_0, bus.frm_cnt_1);
    end
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    do_frame(1'b1, 1'b0, 1'b0, 3, 100);
  endtask

  task automatic test_round_robin();
    apply_reset();
    repeat (4) do_frame(1'b1, 1'b1, 1'b0, int'($urandom_range(5, 0)), int'($urandom_range(10, 1)));
    n_chk++;
    if ({bus.frm_cnt_0, bus.frm_cnt_1} !== {16'd2, 16'd2}) begin
      n_fail++;
      $display("FAIL rr_counts: got %0d/%0d want 2/2", bus.frm_cnt_0, bus.frm_cnt_1);
    end
  endtask

  task automatic test_start_timeout();
    do_frame(1'b0, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_busy_in_idle();
    bus.tx_busy = 1'b1;
    bus.req_0   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_chk++;
      if (obs !== pack(S_IDLE, 1'b0, 1'b0, m_sel, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL busy_idle: got %b want %b", obs, pack(S_IDLE, 1'b0, 1'b0, m_sel, 1'b0, 1'b0));
      end
    end
    do_frame(1'b1, 1'b0, 1'b0, 2, 5);
  endtask

  task automatic test_reset_mid_frame();
    do_frame(1'b1, 1'b0, 1'b0, 0, 3);
    bus.req_1 = 1'b1;
    @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (bus.arb_state !== S_ACTIVE || bus.gnt_1 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: got state %0d gnt_1 %b want 2 1", bus.arb_state, bus.gnt_1);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({obs, bus.frm_cnt_0, bus.frm_cnt_1} !== {pack(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got %b %h %h want %b 0 0", obs, bus.frm_cnt_0, bus.frm_cnt_1,
               pack(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.req_1   = 1'b0;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs !== pack(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) || bus.frm_cnt_0 !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b cnt0 %h want %b 0", obs, bus.frm_cnt_0,
               pack(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    do_frame(1'b1, 1'b1, 1'b0, 1, 2);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frm_cnt_0_q = 16'hFFFF;
    @(negedge clk);
    release dut.frm_cnt_0_q;
    @(negedge clk);
    m_cnt[0] = 16'hFFFF;
    n_chk++;
    if (bus.frm_cnt_0 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h want ffff", bus.frm_cnt_0);
    end
    do_frame(1'b1, 1'b0, 1'b0, 1, 3);
    n_chk++;
    if (bus.frm_cnt_0 !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_result: got %h want 0000", bus.frm_cnt_0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int  k;
      bit  to;
      k  = int'($urandom_range(2, 0));
      to = ($urandom_range(7, 0) == 0);
      repeat (int'($urandom_range(3, 0))) begin
        @(negedge clk);
        n_chk++;
        if (obs !== pack(S_IDLE, 1'b0, 1'b0, m_sel, 1'b0, 1'b0)) begin
          n_fail++;
          $display("FAIL idle_wait: got %b want %b", obs, pack(S_IDLE, 1'b0, 1'b0, m_sel, 1'b0, 1'b0));
        end
      end
      do_frame(k != 1, k != 0, to, int'($urandom_range(STO - 1, 0)), int'($urandom_range(20, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_start_timeout();
    test_busy_in_idle();
    test_reset_mid_frame();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter pIFG_CYCLES, default 48, inter-frame gap in Clk cycles (96 bit times at 2 bits/cycle).
REQ-002 Parameter pSTART_TO, default 16, Clk cycles allowed from start pulse to Tx_Busy rising.
REQ-003 Clk  input  1  single clock; all logic on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Req_0  input  1  requester 0 has a complete frame staged (level).
REQ-006 Req_1  input  1  requester 1 has a complete frame staged (level).
REQ-007 Tx_Busy  input  1  transmit controller active (its Tx_En), high for the whole frame.
REQ-008 Gnt_0  output  1  requester 0 owns the transmit path.
REQ-009 Gnt_1  output  1  requester 1 owns the transmit path.
REQ-010 Sel  output  1  datapath mux select: 0 = requester 0, 1 = requester 1.
REQ-011 Eth_Pkt_Rdy  output  1  one-cycle start pulse to the transmit controller.
REQ-012 Start_Err  output  1  one-cycle pulse on start timeout.
REQ-013 Frm_Cnt_0  output  16  frames completed for requester 0.
REQ-014 Frm_Cnt_1  output  16  frames completed for requester 1.
REQ-015 Arb_State  output  2  current state encoding: IDLE=0, GRANT=1, ACTIVE=2, IFG=3.

Function
REQ-016 States SHALL be IDLE, GRANT, ACTIVE, IFG; all outputs SHALL be registered.
REQ-017 IDLE: if Tx_Busy=0 and (Req_0 or Req_1), next cycle enter GRANT; if Tx_Busy=1, remain IDLE and grant nothing.
REQ-018 Selection: single request wins; both requesting, winner is the requester not in Last_Sel (round-robin); Last_Sel updates on entering GRANT.
REQ-019 On entering GRANT: winner's Gnt=1, other Gnt=0, Sel=winner, Eth_Pkt_Rdy=1 for exactly that first GRANT cycle.
REQ-020 GRANT: Tx_Busy=1 -> ACTIVE next cycle; timeout counter cleared on entry, increments each GRANT cycle.
REQ-021 GRANT: counter reaching pSTART_TO-1 with Tx_Busy=0 -> Start_Err pulse 1 cycle, Gnt_0=Gnt_1=0, enter IFG; Frm_Cnt unchanged.
REQ-022 ACTIVE: Gnt and Sel held; Tx_Busy=0 -> next cycle enter IFG, Gnt_0=Gnt_1=0, Frm_Cnt of owner +1.
REQ-023 Frm_Cnt SHALL wrap 16'hFFFF -> 0 silently.
REQ-024 IFG: counter loaded on entry, SHALL stay exactly pIFG_CYCLES cycles, then IDLE; Req ignored during IFG.
REQ-025 Sel SHALL hold its last value outside GRANT/ACTIVE.
REQ-026 Requesters SHALL drop Req on the falling edge of their Gnt if no further frame; Req still high in IDLE is a new frame.
REQ-027 Tx_Busy falling in GRANT before rising, or Req dropping during GRANT/ACTIVE, SHALL be ignored; only Tx_Busy and timeout advance state.
REQ-028 Gnt_0 and Gnt_1 SHALL never be high simultaneously.

Reset
REQ-029 Rst=1 SHALL immediately force IDLE, Gnt_0=Gnt_1=0, Sel=0, Eth_Pkt_Rdy=0, Start_Err=0, Frm_Cnt_0=Frm_Cnt_1=0, counters 0, Last_Sel=1 (requester 0 wins first tie).
REQ-030 Reset mid-frame SHALL abort without incrementing any counter; first cycle after release is IDLE.

Verification
REQ-031 Req_0=1 only; Tx_Busy rises 3 cycles after Eth_Pkt_Rdy, high 100 cycles -> Gnt_0 high GRANT..ACTIVE, single Eth_Pkt_Rdy, Frm_Cnt_0=1, IFG 48 cycles, back to IDLE.
REQ-032 Req_0=Req_1=1 held continuously, 4 frames -> grant order 0,1,0,1; Frm_Cnt_0=2, Frm_Cnt_1=2; gaps between Tx_Busy fall and next Eth_Pkt_Rdy >= 49 cycles.
REQ-033 Req_1=1, Tx_Busy never rises -> Start_Err pulse after 16 GRANT cycles, Gnt_1 drops, IFG, Frm_Cnt_1=0.
REQ-034 Tx_Busy=1 held in IDLE with Req_0=1 -> no grant; release Tx_Busy -> GRANT next cycle.
REQ-035 Assert Rst during ACTIVE -> all outputs at reset values same cycle, counters 0.
REQ-036 Preload Frm_Cnt_0 to 16'hFFFF via 65535 short frames (or force) then one frame -> Frm_Cnt_0=0.
